apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 180 ++++++++++++++++++
 tb/tb_apb_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// This block bridges a simple valid/ready command port to an APB completer. It
// runs one transfer at a time through three phases:
//   IDLE   -> SETUP  : a command is accepted and latched into PWRITE/PADDR/PWDATA
//   SETUP  -> ACCESS : always, after exactly one cycle
//   ACCESS -> IDLE   : when PREADY is seen, or when the wait budget runs out
//
// When a transfer ends, rsp_valid pulses for exactly one cycle. rsp_rdata and
// rsp_err then keep their values until the next completion.
//
// Ports
//   PCLK, PRESET            clock and synchronous active-high reset
//   cmd_valid / cmd_ready   local request handshake
//   cmd_write               1 = write, 0 = read
//   cmd_addr                transfer address
//   cmd_wdata               write data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               read data (0 for writes and aborted transfers)
//   rsp_err                 completer error or timeout abort
//   PSEL/PENABLE/PWRITE     APB control (registered)
//   PADDR/PWDATA            APB address and write data (registered)
//   PRDATA/PREADY/PSLVERR   APB completer response, sampled only in ACCESS
//
// Parameters
//   AWIDTH   APB address width
//   DWIDTH   APB data width
//   TIMEOUT  number of ACCESS wait cycles tolerated before abort (1..255).
//            A completer that never answers gets TIMEOUT+1 ACCESS cycles in all.
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int unsigned AWIDTH  = 4,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // The wait budget is held in an 8-bit counter, so the limit is narrowed
    // to 8 bits once here.
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r;
    logic [7:0]  wait_cnt_r;

    // These are decoded from the registered state and the completer inputs.
    // They are only meaningful in ACCESS.
    logic              done_s;
    logic              expire_s;
    logic [DWIDTH-1:0] cpl_rdata_s;

    // A request is accepted only in IDLE and never while reset is asserted.
    assign cmd_ready = (state_r == IDLE) && !PRESET;

    // Decode how the current ACCESS cycle ends. PREADY has priority over
    // the timeout, so a completer that answers on the very last allowed cycle
    // still finishes normally.
    always_comb begin
        done_s      = 1'b0;
        expire_s    = 1'b0;
        cpl_rdata_s = {DWIDTH{1'b0}};
        if (state_r == ACCESS) begin
            if (PREADY) begin
                done_s = 1'b1;
            end else if (wait_cnt_r == TIMEOUT_C) begin
                expire_s = 1'b1;
            end else begin
                done_s   = 1'b0;
                expire_s = 1'b0;
            end
        end else begin
            done_s   = 1'b0;
            expire_s = 1'b0;
        end
        // Writes return zero data so that a stale PRDATA never leaks out.
        if (PWRITE) begin
            cpl_rdata_s = {DWIDTH{1'b0}};
        end else begin
            cpl_rdata_s = PRDATA;
        end
    end

    // Transfer sequencer: state, wait counter and every output register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= {AWIDTH{1'b0}};
            PWDATA     <= {DWIDTH{1'b0}};
            rsp_valid  <= 1'b0;
            rsp_rdata  <= {DWIDTH{1'b0}};
            rsp_err    <= 1'b0;
        end else begin
            // Completion is a single-cycle pulse. It is re-raised only below.
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    // PADDR/PWRITE/PWDATA keep their last values until the
                    // next accepted command overwrites them.
                    if (cmd_valid) begin
                        PWRITE     <= cmd_write;
                        PADDR      <= cmd_addr;
                        PWDATA     <= cmd_wdata;
                        PSEL       <= 1'b1;
                        wait_cnt_r <= 8'd0;
                        state_r    <= SETUP;
                    end else begin
                        state_r    <= IDLE;
                    end
                end

                SETUP: begin
                    PSEL    <= 1'b1;
                    PENABLE <= 1'b1;
                    state_r <= ACCESS;
                end

                ACCESS: begin
                    if (done_s) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= cpl_rdata_s;
                        state_r   <= IDLE;
                    end else if (expire_s) begin
                        // The completer never answered, so the transfer is
                        // dropped and reported as an error with no data.
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= {DWIDTH{1'b0}};
                        state_r   <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                        state_r    <= ACCESS;
                    end
                end

                default: begin
                    // The unused encoding falls back to a quiet bus.
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// This bench drives apb_master (TIMEOUT=4) from a per-cycle vector table. Each
// row holds the inputs applied before a rising edge and the outputs expected
// just after that edge. The timeout and late-PREADY corner cases are run as
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_apb_master;

    logic       pclk = 1'b0;
    logic       preset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    apb_master #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT(4)) dut (
        .PCLK      (pclk),
        .PRESET    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic       w;
        logic [3:0] a;
        logic [7:0] wd;
        logic [7:0] prd;
        logic       rdy;
        logic       err;
        logic       e_psel;
        logic       e_pen;
        logic       e_pwr;
        logic [3:0] e_paddr;
        logic [7:0] e_pwd;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       e_re;
        logic       e_crdy;
    } vec_t;

    vec_t tbl [28];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
        end
    endtask

    // Issue a read to address 5 and count the ACCESS cycles it takes. The
    // completer raises PREADY on ACCESS cycle ready_at; 0 means never.
    task automatic access_run(input int ready_at, input logic [7:0] prd, output int n_acc);
        n_acc     = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd5;
        cmd_wdata = 8'h00;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        prdata    = prd;
        tick();
        while (penable === 1'b1 && n_acc < 20) begin
            n_acc++;
            pready = (n_acc == ready_at);
            tick();
        end
        pready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        //              rst   v     w     a      wd     prd    rdy   err  | psel  pen   pwr   paddr  pwd    rv    rd     re    crdy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        // write addr 3 / A5, zero wait
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b1};
        // read addr 6, two wait states, PRDATA 3C
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'd6, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 8'h11, 1'b1, 8'h3C, 1'b0, 1'b1};
        // completer inputs outside ACCESS are ignored; the response holds
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 8'h11, 1'b0, 8'h3C, 1'b0, 1'b1};
        // read addr 9 with slave error
        tbl[11] = '{1'b0, 1'b1, 1'b0, 4'd9, 8'h22, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 8'h22, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 8'h22, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 8'h22, 1'b1, 8'h5A, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 8'h22, 1'b0, 8'h5A, 1'b1, 1'b1};
        // back-to-back writes, cmd_valid held high
        tbl[15] = '{1'b0, 1'b1, 1'b1, 4'd1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 8'h10, 1'b0, 8'h5A, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 4'd1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 8'h10, 1'b0, 8'h5A, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 4'd1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 8'h10, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 4'd2, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 4'd2, 8'h20, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 4'd2, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 8'h20, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 4'd3, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 1'b1, 4'd3, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0};
        // reset during ACCESS of the 3rd write: everything clears, no pulse
        tbl[23] = '{1'b1, 1'b1, 1'b1, 4'd3, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 1'b1, 1'b1, 4'd4, 8'h40, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[25] = '{1'b0, 1'b1, 1'b1, 4'd4, 8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[26] = '{1'b0, 1'b1, 1'b1, 4'd4, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 8'h40, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[27] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 8'h40, 1'b0, 8'h00, 1'b0, 1'b1};

        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0;
        cmd_wdata = 8'h00; prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;

        for (int i = 0; i < 28; i++) begin
            preset    = tbl[i].rst;
            cmd_valid = tbl[i].v;
            cmd_write = tbl[i].w;
            cmd_addr  = tbl[i].a;
            cmd_wdata = tbl[i].wd;
            prdata    = tbl[i].prd;
            pready    = tbl[i].rdy;
            pslverr   = tbl[i].err;
            tick();
            chk("psel",      i, 32'(psel),      32'(tbl[i].e_psel));
            chk("penable",   i, 32'(penable),   32'(tbl[i].e_pen));
            chk("pwrite",    i, 32'(pwrite),    32'(tbl[i].e_pwr));
            chk("paddr",     i, 32'(paddr),     32'(tbl[i].e_paddr));
            chk("pwdata",    i, 32'(pwdata),    32'(tbl[i].e_pwd));
            chk("rsp_valid", i, 32'(rsp_valid), 32'(tbl[i].e_rv));
            chk("rsp_rdata", i, 32'(rsp_rdata), 32'(tbl[i].e_rd));
            chk("rsp_err",   i, 32'(rsp_err),   32'(tbl[i].e_re));
            chk("cmd_ready", i, 32'(cmd_ready), 32'(tbl[i].e_crdy));
        end

        // PREADY arrives on the last allowed ACCESS cycle (the 5th with
        // TIMEOUT=4), so the transfer completes normally.
        access_run(5, 8'hC3, n_acc);
        chk("late_ready_access_cycles", 100, 32'(n_acc),     32'd5);
        chk("late_ready_rsp_valid",     100, 32'(rsp_valid), 32'd1);
        chk("late_ready_rsp_err",       100, 32'(rsp_err),   32'd0);
        chk("late_ready_rsp_rdata",     100, 32'(rsp_rdata), 32'hC3);
        chk("late_ready_psel",          100, 32'(psel),      32'd0);

        // PREADY never arrives: 5 ACCESS cycles, then abort with an error.
        access_run(0, 8'h99, n_acc);
        chk("timeout_access_cycles", 101, 32'(n_acc),     32'd5);
        chk("timeout_rsp_valid",     101, 32'(rsp_valid), 32'd1);
        chk("timeout_rsp_err",       101, 32'(rsp_err),   32'd1);
        chk("timeout_rsp_rdata",     101, 32'(rsp_rdata), 32'h00);
        chk("timeout_psel",          101, 32'(psel),      32'd0);
        chk("timeout_penable",       101, 32'(penable),   32'd0);

        tick();
        chk("post_timeout_rsp_valid", 102, 32'(rsp_valid), 32'd0);
        chk("post_timeout_rsp_err",   102, 32'(rsp_err),   32'd1);
        chk("post_timeout_rsp_rdata", 102, 32'(rsp_rdata), 32'h00);
        chk("post_timeout_cmd_ready", 102, 32'(cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
